// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Holds the PC, requests one word at a time from instruction memory and
// latches the returned word into the instruction register, exposing the
// decoder fields. A consumed instruction advances the PC by 4, or to the
// redirect target when pcs is set.
//
// Ports
//   clk, reset              system clock, async active-low reset
//   imem_req/addr           word request to instruction memory (addr = PC)
//   imem_rdata/valid        memory response
//   stall                   downstream hold; instruction not consumed while high
//   pcs, pc_target          taken redirect and its target
//   instr, instr_valid      instruction register and its valid flag
//   cond/op/funct/rd        decoder fields sliced from instr
//   pc_plus8                architectural R15 read value
//   retired                 count of consumed instructions
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | post-reset, nothing outstanding
// ST_REQ  | request at PC outstanding, waiting for imem_valid
// ST_HOLD | instr valid, waiting for downstream to consume it
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   input  logic        stall,
   input  logic        pcs,
   input  logic [31:0] pc_target,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [3:0]  cond,
   output logic [1:0]  op,
   output logic [5:0]  funct,
   output logic [3:0]  rd,
   output logic [31:0] pc_plus8,
   output logic [31:0] retired
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] retired_q, retired_d;
   logic        consume;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= 32'h0;
         retired_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      consume   = (state_q == ST_HOLD) && !stall;
      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (imem_valid) begin
               instr_d = imem_rdata;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (consume) begin
               retired_d = retired_q + 32'd1;
               state_d   = ST_REQ;
               // Redirect target is word-aligned by masking the low bits.
               if (pcs) pc_d = pc_target & 32'hFFFF_FFFC;
               else     pc_d = pc_q + 32'd4;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decode straight from state so reset drops them at once.
   assign imem_req    = (state_q == ST_REQ);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == ST_HOLD);
   assign instr       = instr_q;
   assign cond        = instr_q[31:28];
   assign op          = instr_q[27:26];
   assign funct       = instr_q[25:20];
   assign rd          = instr_q[15:12];
   assign pc_plus8    = pc_q + 32'd8;
   assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_valid = 1'b0;
   logic        stall = 1'b0;
   logic        pcs = 1'b0;
   logic [31:0] pc_target = 32'h0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [3:0]  cond;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  rd;
   logic [31:0] pc_plus8;
   logic [31:0] retired;

   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_rdata = 32'h0;
   logic        w_valid = 1'b0;
   logic        w_stall = 1'b0;
   logic        w_pcs = 1'b0;
   logic [31:0] w_target = 32'h0;
   logic [31:0] w_instr;
   logic        w_instr_valid;
   logic [3:0]  w_cond;
   logic [1:0]  w_op;
   logic [5:0]  w_funct;
   logic [3:0]  w_rd;
   logic [31:0] w_plus8;
   logic [31:0] w_retired;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
      .pcs(pcs), .pc_target(pc_target), .instr(instr), .instr_valid(instr_valid),
      .cond(cond), .op(op), .funct(funct), .rd(rd), .pc_plus8(pc_plus8),
      .retired(retired)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
      .imem_rdata(w_rdata), .imem_valid(w_valid), .stall(w_stall),
      .pcs(w_pcs), .pc_target(w_target), .instr(w_instr), .instr_valid(w_instr_valid),
      .cond(w_cond), .op(w_op), .funct(w_funct), .rd(w_rd), .pc_plus8(w_plus8),
      .retired(w_retired)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      imem_valid = 1'b0; stall = 1'b0; pcs = 1'b0; w_valid = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_ivalid got %b want 0", instr_valid); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
      checks++; if ({cond, op, funct, rd} !== 16'h0) begin errors++; $display("FAIL rst_fields got %h want 0", {cond, op, funct, rd}); end
      checks++; if (pc_plus8 !== 32'd8) begin errors++; $display("FAIL rst_pc8 got %h want 8", pc_plus8); end
      checks++; if (retired !== 32'h0) begin errors++; $display("FAIL rst_retired got %0d want 0", retired); end
      reset = 1'b1;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h want 1/0", imem_req, imem_addr); end
      imem_rdata = 32'hE280_1005; imem_valid = 1'b1;
      step();
      imem_valid = 1'b0;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_ivalid got %b want 1", instr_valid); end
      checks++; if (op !== 2'b00 || funct !== 6'b101000 || rd !== 4'b0001 || cond !== 4'b1110)
         begin errors++; $display("FAIL first_fields got op=%b funct=%b rd=%b cond=%b", op, funct, rd, cond); end
      checks++; if (pc_plus8 !== 32'd8) begin errors++; $display("FAIL first_pc8 got %h want 8", pc_plus8); end
   endtask

   task automatic test_sequential();
      do_reset();
      step();
      for (int i = 0; i < 4; i++) begin
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || instr_valid !== 1'b0)
            begin errors++; $display("FAIL seq_req%0d got req=%b addr=%h iv=%b want 1/%h/0", i, imem_req, imem_addr, instr_valid, 4 * i); end
         imem_rdata = $urandom; imem_valid = 1'b1;
         step();
         imem_valid = 1'b0;
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_iv%0d got %b want 1", i, instr_valid); end
         step();
      end
      checks++; if (retired !== 32'd4) begin errors++; $display("FAIL seq_retired got %0d want 4", retired); end
   endtask

   task automatic test_branch();
      do_reset();
      step();
      imem_valid = 1'b1; imem_rdata = 32'h1111_1111;
      step();
      imem_valid = 1'b0;
      step();
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL br_seq got %h want 4", imem_addr); end
      imem_valid = 1'b1; imem_rdata = 32'hEA00_0040;
      step();
      imem_valid = 1'b0; pcs = 1'b1; pc_target = 32'h0000_0103;
      step();
      pcs = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100)
         begin errors++; $display("FAIL br_target got req=%b addr=%h want 1/100", imem_req, imem_addr); end
   endtask

   task automatic test_wait_stall();
      logic [31:0] held;
      do_reset();
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL wait%0d got req=%b addr=%h iv=%b", i, imem_req, imem_addr, instr_valid); end
      end
      held = 32'hCAFE_0001;
      imem_rdata = held; imem_valid = 1'b1; stall = 1'b1;
      step();
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (instr !== held || instr_valid !== 1'b1 || retired !== 32'h0 || imem_req !== 1'b0)
            begin errors++; $display("FAIL stall%0d got instr=%h iv=%b ret=%0d req=%b want %h/1/0/0", i, instr, instr_valid, retired, imem_req, held); end
      end
      stall = 1'b0; imem_valid = 1'b0;
      step();
      checks++; if (retired !== 32'd1 || imem_addr !== 32'h4 || instr !== held)
         begin errors++; $display("FAIL stall_release got ret=%0d addr=%h instr=%h want 1/4/%h", retired, imem_addr, instr, held); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      step();
      imem_valid = 1'b1; imem_rdata = 32'h2222_2222;
      step();
      imem_valid = 1'b0; pcs = 1'b1; pc_target = 32'h40;
      step();
      pcs = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
         begin errors++; $display("FAIL mid_setup got req=%b addr=%h want 1/40", imem_req, imem_addr); end
      #3 reset = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0)
         begin errors++; $display("FAIL mid_async got req=%b iv=%b addr=%h want 0/0/0", imem_req, instr_valid, imem_addr); end
      imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
      step();
      checks++; if (instr !== 32'h0 || retired !== 32'h0)
         begin errors++; $display("FAIL mid_late got instr=%h ret=%0d want 0/0", instr, retired); end
      imem_valid = 1'b0; reset = 1'b1;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0)
         begin errors++; $display("FAIL mid_restart got req=%b addr=%h iv=%b instr=%h", imem_req, imem_addr, instr_valid, instr); end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, exp_ret, word;
      int w, s;
      do_reset();
      exp_pc = 32'h0; exp_ret = 32'h0;
      step();
      for (int n = 0; n < 30; n++) begin
         checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0)
            begin errors++; $display("FAIL rnd_req%0d got req=%b addr=%h iv=%b want 1/%h/0", n, imem_req, imem_addr, instr_valid, exp_pc); end
         w = $urandom_range(0, 3);
         for (int k = 0; k < w; k++) step();
         word = $urandom;
         imem_rdata = word; imem_valid = 1'b1;
         step();
         imem_valid = 1'b0;
         checks++; if (instr_valid !== 1'b1 || instr !== word || cond !== word[31:28] || op !== word[27:26]
                       || funct !== word[25:20] || rd !== word[15:12])
            begin errors++; $display("FAIL rnd_instr%0d got iv=%b instr=%h want 1/%h", n, instr_valid, instr, word); end
         s = $urandom_range(0, 3);
         stall = 1'b1;
         for (int k = 0; k < s; k++) begin
            imem_valid = 1'($urandom); imem_rdata = $urandom;
            pcs = 1'($urandom); pc_target = $urandom;
            step();
         end
         imem_valid = 1'b0; stall = 1'b0;
         pcs = 1'($urandom); pc_target = $urandom;
         checks++; if (instr !== word || retired !== exp_ret)
            begin errors++; $display("FAIL rnd_hold%0d got instr=%h ret=%0d want %h/%0d", n, instr, retired, word, exp_ret); end
         exp_ret = exp_ret + 1;
         exp_pc  = pcs ? {pc_target[31:2], 2'b00} : exp_pc + 32'd4;
         step();
         pcs = 1'b0;
         checks++; if (retired !== exp_ret || pc_plus8 !== exp_pc + 32'd8)
            begin errors++; $display("FAIL rnd_ret%0d got ret=%0d pc8=%h want %0d/%h", n, retired, pc_plus8, exp_ret, exp_pc + 32'd8); end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      checks++; if (w_addr !== 32'hFFFF_FFFC || w_plus8 !== 32'h4)
         begin errors++; $display("FAIL wrap_rst got addr=%h pc8=%h want fffffffc/4", w_addr, w_plus8); end
      step();
      w_valid = 1'b1; w_rdata = 32'hE1A0_0000;
      step();
      w_valid = 1'b0;
      checks++; if (w_instr_valid !== 1'b1 || w_plus8 !== 32'h4)
         begin errors++; $display("FAIL wrap_hold got iv=%b pc8=%h want 1/4", w_instr_valid, w_plus8); end
      step();
      checks++; if (w_req !== 1'b1 || w_addr !== 32'h0 || w_retired !== 32'd1)
         begin errors++; $display("FAIL wrap_next got req=%b addr=%h ret=%0d want 1/0/1", w_req, w_addr, w_retired); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_wait_stall();
      test_mid_reset();
      test_random();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
